uart_cmd_ctrl: RTL and testbench

- Parametrised successor to the stopwatch/watch UART control unit.
- Decodes single-byte ASCII commands into a mode select and held button pulses, and merges them with the board switches and debounced buttons.
- New relative to the previous generation: configurable mode count and watch-mode index, an independent hold timer per button, case-insensitive commands, and a one-byte ACK/NAK/status reply to the UART transmitter.
- Sits between uart_rx/uart_tx and the stopwatch/watch datapaths.

---
 rtl/uart_cmd_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: decodes single-byte ASCII UART commands into a mode select,
// held button pulses and a watch reset, merges them with the board switches
// and debounced buttons, and returns a one-byte ACK/NAK/status reply.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   rx_data, rx_done    received byte and its one-cycle valid strobe
//   tx_busy             uart_tx is shifting a byte
//   tx_start, tx_data   one-cycle send request and the reply byte
//   sw                  sw[MW-1:0] board mode, sw[MW] priority (1 = UART only)
//   Btn_L/R/U/D         debounced board buttons: Clear, Start/Stop, Min Up, Hour Up
//   mode                final mode select
//   btn_ctl             final buttons {Hour Up, Minute Up, Start/Stop, Clear}
//   rst_watch           one-cycle watch reset
module uart_cmd_ctrl #(
    parameter int unsigned HOLD_CLKS  = 2_000_000,
    parameter int unsigned NUM_MODES  = 3,
    parameter int unsigned WATCH_MODE = NUM_MODES - 1,
    parameter int unsigned MW         = $clog2(NUM_MODES),
    parameter int unsigned W          = $clog2(HOLD_CLKS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    input  logic          tx_busy,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic [MW:0]   sw,
    input  logic          Btn_L,
    input  logic          Btn_R,
    input  logic          Btn_U,
    input  logic          Btn_D,
    output logic [MW-1:0] mode,
    output logic [3:0]    btn_ctl,
    output logic          rst_watch
);

    localparam int unsigned NUM_BTN = 4;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_LC_A  = 8'h61;
    localparam logic [7:0] CH_LC_Z  = 8'h7A;
    localparam logic [7:0] CASE_OFS = 8'h20;
    localparam logic [7:0] CH_C     = 8'h43;
    localparam logic [7:0] CH_S     = 8'h53;
    localparam logic [7:0] CH_M     = 8'h4D;
    localparam logic [7:0] CH_H     = 8'h48;
    localparam logic [7:0] CH_R     = 8'h52;
    localparam logic [7:0] CH_Q     = 8'h3F;
    localparam logic [7:0] CH_K     = 8'h4B;
    localparam logic [7:0] CH_E     = 8'h45;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } reply_state_t;

    // Registers
    logic [MW-1:0]      r_uart_mode;
    logic               r_rst_watch;
    logic               r_buf_vld;
    logic [7:0]         r_buf;
    reply_state_t       r_state;
    logic               r_tx_start;
    logic [7:0]         r_tx_data;
    logic [W-1:0]       r_cnt [NUM_BTN];

    // Wires
    logic [7:0]         w_cmd;
    logic [7:0]         w_digit;
    logic               w_in_watch;
    logic [7:0]         w_reply;
    logic               w_mode_ld;
    logic [MW-1:0]      w_mode_nxt;
    logic [NUM_BTN-1:0] w_hold_ld;
    logic               w_rst_watch;
    logic [NUM_BTN-1:0] w_btn_uart;
    reply_state_t       w_state_nxt;
    logic               w_prio;
    logic [MW-1:0]      w_board_mode;

    // Fold lowercase letters onto uppercase so commands are case-insensitive
    always_comb begin
        w_cmd = rx_data;
        if (rx_data >= CH_LC_A && rx_data <= CH_LC_Z) begin
            w_cmd = rx_data - CASE_OFS;
        end
    end

    assign w_digit    = w_cmd - CH_0;
    assign w_in_watch = (r_uart_mode == MW'(WATCH_MODE));

    // Command decode: effects and reply byte for the byte on rx_data
    always_comb begin
        w_reply     = CH_E;
        w_mode_ld   = 1'b0;
        w_mode_nxt  = r_uart_mode;
        w_hold_ld   = '0;
        w_rst_watch = 1'b0;
        if (w_cmd >= CH_0 && w_cmd <= CH_9) begin
            if (32'(w_digit) < NUM_MODES) begin
                w_mode_ld  = 1'b1;
                w_mode_nxt = MW'(w_digit);
                w_reply    = CH_K;
            end
        end else begin
            case (w_cmd)
                CH_C: begin
                    if (!w_in_watch) begin
                        w_hold_ld[0] = 1'b1;
                        w_reply      = CH_K;
                    end
                end
                CH_S: begin
                    if (!w_in_watch) begin
                        w_hold_ld[1] = 1'b1;
                        w_reply      = CH_K;
                    end
                end
                CH_M: begin
                    if (w_in_watch) begin
                        w_hold_ld[2] = 1'b1;
                        w_reply      = CH_K;
                    end
                end
                CH_H: begin
                    if (w_in_watch) begin
                        w_hold_ld[3] = 1'b1;
                        w_reply      = CH_K;
                    end
                end
                CH_R: begin
                    if (w_in_watch) begin
                        w_rst_watch = 1'b1;
                        w_reply     = CH_K;
                    end
                end
                CH_Q: begin
                    w_reply = CH_0 + 8'(r_uart_mode);
                end
                default: begin
                    w_reply = CH_E;
                end
            endcase
        end
    end

    // UART mode register and one-cycle watch reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_uart_mode <= '0;
            r_rst_watch <= 1'b0;
        end else begin
            r_rst_watch <= rx_done & w_rst_watch;
            if (rx_done && w_mode_ld) begin
                r_uart_mode <= w_mode_nxt;
            end
        end
    end

    // Independent per-button hold counters; a load retriggers to the full length
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_hold
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt[g] <= '0;
            end else if (rx_done && w_hold_ld[g]) begin
                r_cnt[g] <= W'(HOLD_CLKS);
            end else if (r_cnt[g] != '0) begin
                r_cnt[g] <= r_cnt[g] - W'(1);
            end
        end
        assign w_btn_uart[g] = (r_cnt[g] != '0);
    end

    // One-entry reply buffer; a reply arriving while it is full is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_vld <= 1'b0;
            r_buf     <= 8'h00;
        end else if (r_state == S_SEND) begin
            r_buf_vld <= 1'b0;
        end else if (rx_done && !r_buf_vld) begin
            r_buf_vld <= 1'b1;
            r_buf     <= w_reply;
        end
    end

    // Reply FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Reply FSM next state; WAIT always lasts at least one cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_buf_vld && !tx_busy) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!tx_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered transmit request, high exactly in the SEND cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_tx_start <= (w_state_nxt == S_SEND);
            if (r_state == S_IDLE && w_state_nxt == S_SEND) begin
                r_tx_data <= r_buf;
            end
        end
    end

    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;
    assign rst_watch = r_rst_watch;

    // Output merge: board mode wins when nonzero and priority is off
    assign w_prio       = sw[MW];
    assign w_board_mode = sw[MW-1:0];

    assign mode    = (!w_prio && (w_board_mode != '0)) ? w_board_mode : r_uart_mode;
    assign btn_ctl = w_prio ? w_btn_uart
                            : (w_btn_uart | {Btn_D, Btn_U, Btn_R, Btn_L});

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl with HOLD_CLKS = 8 and NUM_MODES = 3 (watch mode 2).
module tb_uart_cmd_ctrl;

    localparam int unsigned HOLD = 8;
    localparam int unsigned NM   = 3;
    localparam int unsigned WM   = NM - 1;
    localparam int unsigned MWT  = 2;

    logic           clk     = 1'b0;
    logic           rst_n   = 1'b0;
    logic [7:0]     rx_data = 8'h00;
    logic           rx_done = 1'b0;
    logic           tx_busy = 1'b0;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic [MWT:0]   sw      = 3'b100;
    logic           Btn_L   = 1'b0;
    logic           Btn_R   = 1'b0;
    logic           Btn_U   = 1'b0;
    logic           Btn_D   = 1'b0;
    logic [MWT-1:0] mode;
    logic [3:0]     btn_ctl;
    logic           rst_watch;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    uart_cmd_ctrl #(
        .HOLD_CLKS (HOLD),
        .NUM_MODES (NM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .sw        (sw),
        .Btn_L     (Btn_L),
        .Btn_R     (Btn_R),
        .Btn_U     (Btn_U),
        .Btn_D     (Btn_D),
        .mode      (mode),
        .btn_ctl   (btn_ctl),
        .rst_watch (rst_watch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Cycle c starts at the c-th active edge after reset release. A hold
    // button loaded by a command seen at edge c is high through c+HOLD-1.
    int         cyc        = 0;
    int         until_q[4] = '{-1, -1, -1, -1};
    int         m_mode     = 0;
    bit         m_rw       = 1'b0;
    bit         m_full     = 1'b0;
    bit         m_idle     = 1'b1;
    logic [7:0] m_buf      = 8'h00;
    bit         exp_tx_start = 1'b0;
    logic [7:0] exp_tx_data  = 8'h00;
    bit         full_p, idle_p, send_p, watch_p;
    logic [7:0] u, reply;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) until_q[i] = -1;
            m_mode = 0; m_rw = 1'b0; m_full = 1'b0; m_idle = 1'b1; m_buf = 8'h00;
            exp_tx_start = 1'b0; exp_tx_data = 8'h00;
        end else begin
            cyc++;
            full_p = m_full; idle_p = m_idle; send_p = exp_tx_start;
            watch_p = (m_mode == WM);
            // reply path timing
            exp_tx_start = 1'b0;
            if (send_p) begin
                m_full = 1'b0;
                m_idle = 1'b0;
            end else if (!idle_p) begin
                if (!tx_busy) m_idle = 1'b1;
            end else if (full_p && !tx_busy) begin
                exp_tx_start = 1'b1;
                exp_tx_data  = m_buf;
                m_idle       = 1'b0;
            end
            // command effects
            m_rw = 1'b0;
            if (rx_done) begin
                u = rx_data;
                if (u >= "a" && u <= "z") u = u - 8'd32;
                reply = "E";
                if (u >= "0" && u <= "9") begin
                    if (int'(u - "0") < NM) begin
                        m_mode = int'(u - "0");
                        reply  = "K";
                    end
                end else if (u == "C" && !watch_p) begin
                    until_q[0] = cyc + HOLD - 1; reply = "K";
                end else if (u == "S" && !watch_p) begin
                    until_q[1] = cyc + HOLD - 1; reply = "K";
                end else if (u == "M" && watch_p) begin
                    until_q[2] = cyc + HOLD - 1; reply = "K";
                end else if (u == "H" && watch_p) begin
                    until_q[3] = cyc + HOLD - 1; reply = "K";
                end else if (u == "R" && watch_p) begin
                    m_rw = 1'b1; reply = "K";
                end else if (u == "?") begin
                    reply = 8'h30 + 8'(m_mode);
                end
                if (!full_p) begin
                    m_full = 1'b1;
                    m_buf  = reply;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    int         em;
    logic [3:0] eb;
    always @(negedge clk) begin
        if (chk_en) begin
            em = (!sw[MWT] && sw[MWT-1:0] != 0) ? int'(sw[MWT-1:0]) : m_mode;
            for (int i = 0; i < 4; i++) eb[i] = (cyc <= until_q[i]);
            if (!sw[MWT]) eb = eb | {Btn_D, Btn_U, Btn_R, Btn_L};
            chk("mode", int'(mode), em);
            chk("btn_ctl", int'(btn_ctl), int'(eb));
            chk("rst_watch", int'(rst_watch), int'(m_rw));
            chk("tx_start", int'(tx_start), int'(exp_tx_start));
            chk("tx_data", int'(tx_data), int'(exp_tx_data));
        end
    end

    // Output monitor for the hand-computed expectations
    logic [7:0] got_tx[$];
    int         mon_b[4];
    int         mon_ov;
    int         mon_rw;
    always @(negedge clk) begin
        if (tx_start) got_tx.push_back(tx_data);
        for (int i = 0; i < 4; i++) mon_b[i] += int'(btn_ctl[i]);
        if (btn_ctl[1:0] == 2'b11) mon_ov++;
        mon_rw += int'(rst_watch);
    end

    task automatic clear_mon();
        got_tx.delete();
        for (int i = 0; i < 4; i++) mon_b[i] = 0;
        mon_ov = 0;
        mon_rw = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick(1);
        rx_done = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        pulse(b);
        tick(6);
    endtask

    function automatic int tx_at(input int idx);
        if (idx < got_tx.size()) return int'(got_tx[idx]);
        return -1;
    endfunction

    initial begin
        clear_mon();
        tick(2);
        chk_en = 1'b1;
        chk("rst_mode", int'(mode), 0);
        chk("rst_btn", int'(btn_ctl), 0);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_watch0", int'(rst_watch), 0);
        rst_n = 1'b1;
        tick(2);

        // '2' then 'M': Minute Up held exactly HOLD cycles, replies K K
        clear_mon();
        send_cmd("2");
        pulse("M");
        tick(14);
        chk("t1_hold_len", mon_b[2], 8);
        chk("t1_other_bits", mon_b[0] + mon_b[1] + mon_b[3], 0);
        chk("t1_tx_count", got_tx.size(), 2);
        chk("t1_tx0", tx_at(0), 32'h4B);
        chk("t1_tx1", tx_at(1), 32'h4B);

        // mode 0: 'c', 4 cycles later 's' overlap 4 cycles; 'm' rejected
        send_cmd("0");
        clear_mon();
        pulse("c");
        tick(3);
        pulse("s");
        tick(16);
        send_cmd("m");
        tick(4);
        chk("t2_clear_len", mon_b[0], 8);
        chk("t2_start_len", mon_b[1], 8);
        chk("t2_overlap", mon_ov, 4);
        chk("t2_min_bit", mon_b[2], 0);
        chk("t2_tx_count", got_tx.size(), 3);
        chk("t2_tx2", tx_at(2), 32'h45);

        // 'R' in watch mode pulses rst_watch once; in mode 1 it is rejected
        send_cmd("2");
        clear_mon();
        send_cmd("R");
        chk("t3_rw_watch", mon_rw, 1);
        send_cmd("1");
        send_cmd("r");
        chk("t3_rw_total", mon_rw, 1);
        chk("t3_tx_count", got_tx.size(), 3);
        chk("t3_tx2", tx_at(2), 32'h45);

        // illegal digits and status query in mode 1
        clear_mon();
        send_cmd("7");
        send_cmd("3");
        send_cmd("?");
        send_cmd("x");
        chk("t4_mode", int'(mode), 1);
        chk("t4_tx_count", got_tx.size(), 4);
        chk("t4_tx0", tx_at(0), 32'h45);
        chk("t4_tx1", tx_at(1), 32'h45);
        chk("t4_tx2", tx_at(2), 32'h31);
        chk("t4_tx3", tx_at(3), 32'h45);

        // tx_busy held: only the first of three replies survives
        clear_mon();
        tx_busy = 1'b1;
        pulse("0");
        tick(10);
        pulse("?");
        tick(10);
        pulse("C");
        tick(28);
        chk("t5_no_tx_busy", got_tx.size(), 0);
        tx_busy = 1'b0;
        tick(10);
        chk("t5_tx_count", got_tx.size(), 1);
        chk("t5_tx0", tx_at(0), 32'h4B);
        chk("t5_mode", int'(mode), 0);
        chk("t5_clear_len", mon_b[0], 8);

        // output merge and asynchronous reset mid-hold
        send_cmd("2");
        sw = 3'b001;
        Btn_L = 1'b1;
        tick(1);
        chk("t6_board_mode", int'(mode), 1);
        chk("t6_board_btn", int'(btn_ctl[0]), 1);
        sw = 3'b000;
        tick(1);
        chk("t6_zero_board", int'(mode), 2);
        sw = 3'b101;
        tick(1);
        chk("t6_prio_mode", int'(mode), 2);
        chk("t6_prio_btn", int'(btn_ctl), 0);
        Btn_L = 1'b0;
        pulse("M");
        tick(2);
        chk("t6_hold", int'(btn_ctl), 4);
        pulse("H");
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_mode", int'(mode), 0);
        chk("t6_rst_btn", int'(btn_ctl), 0);
        chk("t6_rst_tx_start", int'(tx_start), 0);
        chk("t6_rst_tx_data", int'(tx_data), 0);
        chk("t6_rst_watch", int'(rst_watch), 0);
        tick(2);
        rst_n = 1'b1;
        clear_mon();
        tick(20);
        chk("t6_reply_aborted", got_tx.size(), 0);
        chk("t6_hold_aborted", mon_b[2] + mon_b[3], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
